// File: rtl/mmu_feeder_pkg.sv
// Shared widths, weight-memory element indices, FSM encoding and lane payload for mmu_feeder.
package mmu_feeder_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ACC_W   = 16;
  localparam int unsigned OUT_W   = 8;
  localparam int unsigned MMU_LAT = 2;
  localparam int unsigned N_ELEM  = 8;
  localparam int unsigned N_OUT   = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned FEED_STEPS = 3;
  localparam int unsigned CNT_W   = (MMU_LAT > 4) ? $clog2(MMU_LAT) : 2;

  localparam int unsigned A00 = 0;
  localparam int unsigned A01 = 1;
  localparam int unsigned A10 = 2;
  localparam int unsigned A11 = 3;
  localparam int unsigned B00 = 4;
  localparam int unsigned B01 = 5;
  localparam int unsigned B10 = 6;
  localparam int unsigned B11 = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a0;
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] b0;
    logic [DATA_W-1:0] b1;
  } lanes_t;

  function automatic logic [DATA_W-1:0] elem(input logic [N_ELEM*DATA_W-1:0] mem,
                                             input int unsigned k);
    return mem[k*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/mmu_feeder_if.sv
// Control-unit, weight-memory, MMU and host-pin signals of mmu_feeder; master = feeder side.
interface mmu_feeder_if
  import mmu_feeder_pkg::*;
();

  logic                       feeding_en;
  logic [N_ELEM*DATA_W-1:0]   mem_flat;
  logic [DATA_W-1:0]          mmu_a0;
  logic [DATA_W-1:0]          mmu_a1;
  logic [DATA_W-1:0]          mmu_b0;
  logic [DATA_W-1:0]          mmu_b1;
  logic                       mmu_valid;
  logic                       mmu_clear;
  logic [N_OUT*ACC_W-1:0]     mmu_c;
  logic [OUT_W-1:0]           out_data;
  logic                       out_valid;
  logic [IDX_W-1:0]           out_idx;
  logic                       busy;
  logic                       done;

  modport master (
    input  feeding_en, mem_flat, mmu_c,
    output mmu_a0, mmu_a1, mmu_b0, mmu_b1, mmu_valid, mmu_clear,
           out_data, out_valid, out_idx, busy, done
  );

  modport slave (
    output feeding_en, mem_flat, mmu_c,
    input  mmu_a0, mmu_a1, mmu_b0, mmu_b1, mmu_valid, mmu_clear,
           out_data, out_valid, out_idx, busy, done
  );

endinterface

// File: rtl/mmu_feeder_result_serializer.sv
// Captures the four MMU results and streams them one per cycle, narrowed to OUT_W.
// MMU_FEEDER_SATURATE_EN selects signed clamping instead of truncation.
module mmu_feeder_result_serializer
  import mmu_feeder_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   capture_c,
  input  logic                   out_en_c,
  input  logic [N_OUT*ACC_W-1:0] mmu_c,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  output logic [IDX_W-1:0]       out_idx
);

`ifdef MMU_FEEDER_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

  function automatic logic [OUT_W-1:0] conv(input logic [ACC_W-1:0] x);
`ifdef MMU_FEEDER_SATURATE_EN
    logic signed [ACC_W-1:0] sx;
    sx = $signed(x);
    if (sx > SAT_MAX)      conv = SAT_MAX[OUT_W-1:0];
    else if (sx < SAT_MIN) conv = SAT_MIN[OUT_W-1:0];
    else                   conv = x[OUT_W-1:0];
`else
    conv = x[OUT_W-1:0];
`endif
  endfunction

  logic [N_OUT-1:0][ACC_W-1:0] cap_q, cap_d;
  logic [OUT_W-1:0]            out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;
  logic [IDX_W-1:0]            out_idx_q, out_idx_d;

  // The first output slot reads the freshly captured word in the same cycle it is latched.
  always_comb begin
    cap_d       = cap_q;
    out_idx_d   = '0;
    out_data_d  = '0;
    out_valid_d = out_en_c;
    if (capture_c) cap_d = mmu_c;
    if (out_en_c) begin
      out_idx_d  = out_valid_q ? IDX_W'(out_idx_q + 1'b1) : '0;
      out_data_d = conv(cap_d[out_idx_d]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      cap_q       <= cap_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;

endmodule

// File: rtl/mmu_feeder.sv
// Feeds the 2x2 systolic MMU from weight memory with diagonal skew, then serializes c00..c11.
// Build option: MMU_FEEDER_SATURATE_EN (saturating result narrowing, see serializer).
module mmu_feeder
  import mmu_feeder_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mmu_feeder_if.master  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q;
  lanes_t           lanes_q, lanes_d;
  logic             mmu_valid_q, mmu_valid_d;
  logic             mmu_clear_q, mmu_clear_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_c, abort_c, capture_c, out_en_c;
  logic [IDX_W-1:0] out_idx;

  assign start_c = (state_q == ST_IDLE) && bus.feeding_en && !en_q;
  assign abort_c = !bus.feeding_en &&
                   (state_q inside {ST_CLEAR, ST_FEED, ST_WAIT, ST_OUT});

  // Next state, step counter and registered-output values all derive from state_d.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    capture_c   = 1'b0;
    lanes_d     = '0;
    mmu_valid_d = 1'b0;
    mmu_clear_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE:  if (start_c) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_FEED;
      ST_FEED: begin
        if (cnt_q == CNT_W'(FEED_STEPS - 1)) state_d = ST_WAIT;
        else cnt_d = CNT_W'(cnt_q + 1'b1);
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(MMU_LAT - 1)) begin
          state_d   = ST_OUT;
          capture_c = 1'b1;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      ST_OUT:   if (out_idx == IDX_W'(N_OUT - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (abort_c) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      capture_c = 1'b0;
    end

    out_en_c    = (state_d == ST_OUT);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    mmu_clear_d = (state_d == ST_CLEAR);

    // Diagonal skew: row 1 / column 1 lag row 0 / column 0 by one step.
    if (state_d == ST_FEED) begin
      mmu_valid_d = 1'b1;
      unique case (cnt_d)
        CNT_W'(0): begin
          lanes_d.a0 = elem(bus.mem_flat, A00);
          lanes_d.b0 = elem(bus.mem_flat, B00);
        end
        CNT_W'(1): begin
          lanes_d.a0 = elem(bus.mem_flat, A01);
          lanes_d.a1 = elem(bus.mem_flat, A10);
          lanes_d.b0 = elem(bus.mem_flat, B10);
          lanes_d.b1 = elem(bus.mem_flat, B01);
        end
        default: begin
          lanes_d.a1 = elem(bus.mem_flat, A11);
          lanes_d.b1 = elem(bus.mem_flat, B11);
        end
      endcase
    end
  end

  // en_q resets high so a level already asserted at reset release is not taken as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      en_q        <= 1'b1;
      lanes_q     <= '0;
      mmu_valid_q <= 1'b0;
      mmu_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      en_q        <= bus.feeding_en;
      lanes_q     <= lanes_d;
      mmu_valid_q <= mmu_valid_d;
      mmu_clear_q <= mmu_clear_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  mmu_feeder_result_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture_c (capture_c),
    .out_en_c  (out_en_c),
    .mmu_c     (bus.mmu_c),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .out_idx   (out_idx)
  );

  assign bus.out_idx   = out_idx;
  assign bus.mmu_a0    = lanes_q.a0;
  assign bus.mmu_a1    = lanes_q.a1;
  assign bus.mmu_b0    = lanes_q.b0;
  assign bus.mmu_b1    = lanes_q.b1;
  assign bus.mmu_valid = mmu_valid_q;
  assign bus.mmu_clear = mmu_clear_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mmu_feeder.sv
// Directed bench for mmu_feeder with a cycle-level 2x2 systolic MMU model driving mmu_c.
module tb_mmu_feeder;
  import mmu_feeder_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] el [8];

  mmu_feeder_if bus ();

  mmu_feeder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden systolic array: a flows right, b flows down, one register per hop.
  logic signed [ACC_W-1:0]  acc [4];
  logic signed [DATA_W-1:0] a_d0, b_d0, a_d1, b_d1;

  function automatic logic signed [ACC_W-1:0] prod(input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
    logic signed [ACC_W-1:0] ea, eb;
    ea = ACC_W'(a);
    eb = ACC_W'(b);
    return ea * eb;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.mmu_clear) begin
      for (int i = 0; i < 4; i++) acc[i] <= '0;
      a_d0 <= '0; b_d0 <= '0; a_d1 <= '0; b_d1 <= '0;
    end else begin
      acc[0] <= acc[0] + prod(bus.mmu_a0, bus.mmu_b0);
      acc[1] <= acc[1] + prod(a_d0, bus.mmu_b1);
      acc[2] <= acc[2] + prod(bus.mmu_a1, b_d0);
      acc[3] <= acc[3] + prod(a_d1, b_d1);
      a_d0 <= bus.mmu_a0;
      b_d0 <= bus.mmu_b0;
      a_d1 <= bus.mmu_a1;
      b_d1 <= bus.mmu_b1;
    end
  end

  assign bus.mmu_c = {acc[3], acc[2], acc[1], acc[0]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input int v0, input int v1, input int v2, input int v3,
                         input int v4, input int v5, input int v6, input int v7);
    el[0] = 8'(v0); el[1] = 8'(v1); el[2] = 8'(v2); el[3] = 8'(v3);
    el[4] = 8'(v4); el[5] = 8'(v5); el[6] = 8'(v6); el[7] = 8'(v7);
    bus.mem_flat = {el[7], el[6], el[5], el[4], el[3], el[2], el[1], el[0]};
  endtask

  function automatic logic [31:0] lanes();
    return {bus.mmu_a0, bus.mmu_a1, bus.mmu_b0, bus.mmu_b1};
  endfunction

  // Full run from a rising edge; optionally drops feeding_en during the done cycle.
  task automatic run_check(input logic [7:0] x0, input logic [7:0] x1,
                           input logic [7:0] x2, input logic [7:0] x3, input bit b2b);
    logic [7:0] ex [4];
    ex[0] = x0; ex[1] = x1; ex[2] = x2; ex[3] = x3;
    bus.feeding_en = 1'b1;
    tick();
    chk("c0_clear", {30'd0, bus.mmu_clear, bus.busy}, 32'h3);
    chk("c0_lanes", {bus.mmu_valid, lanes()}, '0);
    tick();
    chk("c1_lanes", {bus.mmu_valid, lanes()}, {1'b1, el[0], 8'd0, el[4], 8'd0});
    tick();
    chk("c2_lanes", {bus.mmu_valid, lanes()}, {1'b1, el[1], el[2], el[6], el[5]});
    tick();
    chk("c3_lanes", {bus.mmu_valid, lanes()}, {1'b1, 8'd0, el[3], 8'd0, el[7]});
    for (int c = 4; c < 6; c++) begin
      tick();
      chk("wait_idle", {bus.mmu_valid, bus.mmu_clear, bus.out_valid, lanes()}, '0);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("out_word", {bus.out_valid, bus.out_idx, bus.out_data, bus.done},
          {1'b1, 2'(i), ex[i], 1'b0});
    end
    tick();
    chk("done_cycle", {bus.done, bus.busy, bus.out_valid, bus.out_data}, {3'b110, 8'd0});
    if (b2b) bus.feeding_en = 1'b0;
    tick();
    chk("post_done", {bus.done, bus.busy, bus.out_valid}, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.feeding_en = 1'b0;
    set_mem(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("reset_outs", {bus.out_data, bus.out_valid, bus.out_idx, bus.busy, bus.done,
                       bus.mmu_valid, bus.mmu_clear}, '0);
    chk("reset_lanes", lanes(), '0);
    rst_n = 1'b1;
    tick();
    tick();

    // Basic product, then feeding_en held high: no restart.
    set_mem(1, 2, 3, 4, 5, 6, 7, 8);
    run_check(8'd19, 8'd22, 8'd43, 8'd50, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_high_idle", {bus.busy, bus.mmu_clear, bus.out_valid, bus.done}, '0);
    end
    bus.feeding_en = 1'b0;
    tick();

    // Signed operands, run twice back-to-back with one low cycle in between.
    set_mem(-1, 2, 3, -4, 5, -6, 7, 8);
    run_check(8'd9, 8'd22, 8'hF3, 8'hCE, 1'b1);
    run_check(8'd9, 8'd22, 8'hF3, 8'hCE, 1'b0);
    bus.feeding_en = 1'b0;
    tick();

    // Overflow: every c = 20000 = 0x4E20.
    set_mem(100, 100, 100, 100, 100, 100, 100, 100);
`ifdef MMU_FEEDER_SATURATE_EN
    run_check(8'd127, 8'd127, 8'd127, 8'd127, 1'b0);
`else
    run_check(8'd32, 8'd32, 8'd32, 8'd32, 1'b0);
`endif
    bus.feeding_en = 1'b0;
    tick();

    // Abort in cycle 2.
    set_mem(1, 2, 3, 4, 5, 6, 7, 8);
    bus.feeding_en = 1'b1;
    tick();
    tick();
    tick();
    bus.feeding_en = 1'b0;
    tick();
    chk("abort_c3", {bus.mmu_valid, bus.busy, lanes()}, '0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_quiet", {bus.out_valid, bus.done, bus.busy}, '0);
    end
    run_check(8'd19, 8'd22, 8'd43, 8'd50, 1'b0);
    bus.feeding_en = 1'b0;
    tick();

    // Reset during OUT at idx 1.
    bus.feeding_en = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("pre_reset_idx1", {bus.out_valid, bus.out_idx, bus.out_data}, {1'b1, 2'd1, 8'd22});
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", {bus.out_data, bus.out_valid, bus.out_idx, bus.busy, bus.done,
                             bus.mmu_valid, bus.mmu_clear}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_reset_quiet", {bus.busy, bus.mmu_clear, bus.out_valid, bus.done}, '0);
    end
    bus.feeding_en = 1'b0;
    tick();
    run_check(8'd19, 8'd22, 8'd43, 8'd50, 1'b0);
    bus.feeding_en = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
